// File: rtl/grn_seq_ctrl.sv
// Genius game sequencer: free-running LFSR colour source, sequence buffer,
// timed playback of the stored sequence and an indexed read port for the checker.
module grn_seq_ctrl #(
    parameter int unsigned         MAX_LEN   = 32,
    parameter int unsigned         COLOR_W   = 2,
    parameter int unsigned         LFSR_W    = 16,
    parameter logic [LFSR_W-1:0]   SEED      = LFSR_W'(16'hACE1),
    parameter int unsigned         TICKS_ON  = 4,
    parameter int unsigned         TICKS_OFF = 2,
    localparam int unsigned        AW        = $clog2(MAX_LEN),
    localparam int unsigned        LW        = $clog2(MAX_LEN + 1)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               i_start,
    input  logic               i_extend,
    input  logic               i_replay,
    input  logic [AW-1:0]      i_rd_addr,
    output logic [COLOR_W-1:0] o_rd_color,
    output logic [COLOR_W-1:0] o_color,
    output logic               o_color_valid,
    output logic [LW-1:0]      o_seq_len,
    output logic               o_busy,
    output logic               o_done,
    output logic               o_full,
    output logic               o_ovf
);

    localparam logic [LFSR_W-1:0] TAPS      = LFSR_W'(16'hB400);
    localparam logic [LFSR_W-1:0] SEED_EFF  = (SEED == '0) ? LFSR_W'(1) : SEED;
    localparam int unsigned       TICK_MAX  = (TICKS_ON > TICKS_OFF) ? TICKS_ON : TICKS_OFF;
    localparam int unsigned       TICK_W    = $clog2(TICK_MAX + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_APPEND,
        S_SHOW_ON,
        S_SHOW_OFF,
        S_DONE
    } state_t;

    state_t               r_state;
    logic [LFSR_W-1:0]    r_lfsr;
    logic [COLOR_W-1:0]   r_buf [MAX_LEN];
    logic [LW-1:0]        r_len;
    logic [AW-1:0]        r_idx;
    logic [TICK_W-1:0]    r_tick;
    logic [COLOR_W-1:0]   r_color;
    logic                 r_valid;
    logic                 r_busy;
    logic                 r_done;
    logic                 r_full;
    logic                 r_ovf;

    logic [LFSR_W-1:0]    w_lfsr_next;
    logic [COLOR_W-1:0]   w_new_color;
    logic [AW-1:0]        w_idx_next;
    logic                 w_last;
    logic                 w_rd_hit;

    assign w_lfsr_next = {1'b0, r_lfsr[LFSR_W-1:1]} ^ (r_lfsr[0] ? TAPS : '0);
    assign w_new_color = r_lfsr[COLOR_W-1:0];
    assign w_idx_next  = r_idx + AW'(1);
    assign w_last      = (LW'(r_idx) == (r_len - LW'(1)));

    // Entries at or beyond the stored length read as 0
    assign w_rd_hit    = (LW'(i_rd_addr) < r_len);
    assign o_rd_color  = w_rd_hit ? r_buf[i_rd_addr] : '0;

    assign o_color       = r_color;
    assign o_color_valid = r_valid;
    assign o_seq_len     = r_len;
    assign o_busy        = r_busy;
    assign o_done        = r_done;
    assign o_full        = r_full;
    assign o_ovf         = r_ovf;

    // Free-running Galois LFSR, advances every cycle regardless of state
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_lfsr <= SEED_EFF;
        end else begin
            r_lfsr <= w_lfsr_next;
        end
    end

    // Sequencer FSM with buffer write and registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_len   <= '0;
            r_idx   <= '0;
            r_tick  <= '0;
            r_color <= '0;
            r_valid <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_full  <= 1'b0;
            r_ovf   <= 1'b0;
            for (int i = 0; i < int'(MAX_LEN); i++) begin
                r_buf[i] <= '0;
            end
        end else begin
            r_done <= 1'b0;
            r_ovf  <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (i_start) begin
                        r_len  <= '0;
                        r_full <= 1'b0;
                    end else if (i_extend) begin
                        if (r_full) begin
                            r_ovf <= 1'b1;
                        end else begin
                            r_state <= S_APPEND;
                            r_busy  <= 1'b1;
                        end
                    end else if (i_replay) begin
                        if (r_len != '0) begin
                            r_idx   <= '0;
                            r_tick  <= '0;
                            r_color <= r_buf[0];
                            r_valid <= 1'b1;
                            r_busy  <= 1'b1;
                            r_state <= S_SHOW_ON;
                        end else begin
                            r_done <= 1'b1;
                        end
                    end
                end
                S_APPEND: begin
                    r_buf[AW'(r_len)] <= w_new_color;
                    r_len   <= r_len + LW'(1);
                    r_full  <= ((r_len + LW'(1)) == LW'(MAX_LEN));
                    r_idx   <= '0;
                    r_tick  <= '0;
                    // Entry 0 is being written this cycle when the buffer was empty
                    r_color <= (r_len == '0) ? w_new_color : r_buf[0];
                    r_valid <= 1'b1;
                    r_state <= S_SHOW_ON;
                end
                S_SHOW_ON: begin
                    if (r_tick == TICK_W'(TICKS_ON - 1)) begin
                        r_tick  <= '0;
                        r_valid <= 1'b0;
                        r_color <= '0;
                        r_state <= S_SHOW_OFF;
                    end else begin
                        r_tick <= r_tick + TICK_W'(1);
                    end
                end
                S_SHOW_OFF: begin
                    if (r_tick == TICK_W'(TICKS_OFF - 1)) begin
                        r_tick <= '0;
                        if (w_last) begin
                            r_done  <= 1'b1;
                            r_state <= S_DONE;
                        end else begin
                            r_idx   <= w_idx_next;
                            r_color <= r_buf[w_idx_next];
                            r_valid <= 1'b1;
                            r_state <= S_SHOW_ON;
                        end
                    end else begin
                        r_tick <= r_tick + TICK_W'(1);
                    end
                end
                S_DONE: begin
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_valid <= 1'b0;
                    r_color <= '0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
